// File: rtl/sabr_accum_pkg.sv
// Shared types and default widths for the SABR product accumulator slice.
// Used by sabr_prod_accum and sabr_sat_add.
package sabr_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int PROD_WIDTH_D = 89;
   localparam int ACC_WIDTH_D  = 96;
   localparam int CNT_WIDTH_D  = 16;

endpackage

// File: rtl/sabr_sat_add.sv
// Unsigned WIDTH-bit adder with a carry flag.
// When SABR_PROD_ACCUM_SAT_EN is defined the sum clamps to all-ones on carry; otherwise it wraps.
module sabr_sat_add
   import sabr_accum_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH_D
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] raw;

   assign raw   = {1'b0, a} + {1'b0, b};
   assign carry = raw[WIDTH];

`ifdef SABR_PROD_ACCUM_SAT_EN
   // Once clamped, any further nonzero beat carries again, so the sum stays pinned.
   assign sum = carry ? '1 : raw[WIDTH-1:0];
`else
   assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/sabr_prod_accum.sv
// Batch accumulator behind the SABR product multiplier: sums N products, holds the result until taken.
// Optional clamp-on-overflow via SABR_PROD_ACCUM_SAT_EN (see sabr_sat_add).
module sabr_prod_accum
   import sabr_accum_pkg::*;
#(
   parameter int PROD_WIDTH = PROD_WIDTH_D,
   parameter int ACC_WIDTH  = ACC_WIDTH_D,
   parameter int CNT_WIDTH  = CNT_WIDTH_D
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_samples,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_sum,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_ovf,
   output logic                  busy
);

   state_t               state_reg, state_next;
   logic [ACC_WIDTH-1:0] acc_reg, acc_next;
   logic [ACC_WIDTH-1:0] beat_ext, add_sum;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [CNT_WIDTH-1:0] n_reg, n_next;
   logic                 ovf_reg, ovf_next;
   logic                 add_carry;
   logic                 beat_fire;

   assign beat_ext  = ACC_WIDTH'(in_data);
   assign cnt_inc   = cnt_reg + CNT_WIDTH'(1);
   assign beat_fire = (state_reg == ACCUM) && in_valid;

   sabr_sat_add #(
      .WIDTH (ACC_WIDTH)
   ) u_add (
      .a     (acc_reg),
      .b     (beat_ext),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      n_next     = n_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
               n_next     = num_samples;
               state_next = (num_samples == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (beat_fire) begin
               acc_next = add_sum;
               cnt_next = cnt_inc;
               ovf_next = ovf_reg | add_carry;
               if (cnt_inc == n_reg) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         n_reg     <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         n_reg     <= n_next;
         ovf_reg   <= ovf_next;
      end
   end

   // Handshake flags decode registered state only, so no input-to-ready/valid paths exist.
   assign in_ready  = (state_reg == ACCUM);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_sum   = acc_reg;
   assign out_count = cnt_reg;
   assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_sabr_prod_accum.sv
// Randomized self-checking bench for sabr_prod_accum: a 96-bit and an 89-bit instance share stimulus.
// Expected sums come from the plain arithmetic total of each job's beats.
module tb_sabr_prod_accum;

   localparam int PW  = 89;
   localparam int AW  = 96;
   localparam int AW2 = 89;
   localparam int CW  = 16;

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic          start;
   logic [CW-1:0] num_samples;
   logic          in_valid;
   logic [PW-1:0] in_data;
   logic          out_ready;

   logic           in_ready_a, out_valid_a, out_ovf_a, busy_a;
   logic [AW-1:0]  out_sum_a;
   logic [CW-1:0]  out_count_a;
   logic           in_ready_b, out_valid_b, out_ovf_b, busy_b;
   logic [AW2-1:0] out_sum_b;
   logic [CW-1:0]  out_count_b;

   int n_checks = 0;
   int n_fail   = 0;
   logic [PW-1:0] job_beats[$];

   always #5 ap_clk = ~ap_clk;

   sabr_prod_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
      .out_count(out_count_a), .out_ovf(out_ovf_a), .busy(busy_a)
   );

   sabr_prod_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) dut_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
      .out_count(out_count_b), .out_ovf(out_ovf_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Result of summing the true total into a w-bit accumulator.
   task automatic model(input logic [127:0] total, input int w,
                        output logic [127:0] s, output logic o);
      logic [127:0] lim;
      lim = (128'd1 << w) - 128'd1;
      o   = (total > lim);
`ifdef SABR_PROD_ACCUM_SAT_EN
      s = o ? lim : total;
`else
      s = total & lim;
`endif
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_in_ready_a"},  in_ready_a,  0);
      check({tag, "_out_valid_a"}, out_valid_a, 0);
      check({tag, "_sum_a"},       out_sum_a,   0);
      check({tag, "_count_a"},     out_count_a, 0);
      check({tag, "_ovf_a"},       out_ovf_a,   0);
      check({tag, "_busy_a"},      busy_a,      0);
      check({tag, "_in_ready_b"},  in_ready_b,  0);
      check({tag, "_out_valid_b"}, out_valid_b, 0);
      check({tag, "_sum_b"},       out_sum_b,   0);
      check({tag, "_busy_b"},      busy_b,      0);
   endtask

   function automatic logic [PW-1:0] rand_prod();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[PW-1:0];
   endfunction

   // Runs one job over job_beats; gap_pct = chance of an idle input cycle, hold = cycles out_ready stays low.
   task automatic run_job(input int n, input int gap_pct, input int hold, input bit poke);
      logic [127:0] total, exp_a, exp_b;
      logic         ovf_a, ovf_b;
      int           idx, guard;
      total = '0;
      foreach (job_beats[i]) total += 128'(job_beats[i]);
      model(total, AW,  exp_a, ovf_a);
      model(total, AW2, exp_b, ovf_b);

      @(negedge ap_clk);
      start       = 1'b1;
      num_samples = CW'(n);
      @(negedge ap_clk);
      start = 1'b0;

      idx   = 0;
      guard = 0;
      while (idx < n && guard < 1000) begin
         check("accum_in_ready_a",  in_ready_a,  1);
         check("accum_in_ready_b",  in_ready_b,  1);
         check("accum_out_valid_a", out_valid_a, 0);
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = in_valid ? job_beats[idx] : rand_prod();
         if (poke && idx == 1) begin
            start       = 1'b1;
            num_samples = CW'(n + 3);
         end else begin
            start = 1'b0;
         end
         @(negedge ap_clk);
         if (in_valid) idx++;
         guard++;
      end
      start = 1'b0;
      check("accum_budget", guard < 1000, 1);

      for (int h = 0; h <= hold; h++) begin
         check("done_out_valid_a", out_valid_a, 1);
         check("done_out_valid_b", out_valid_b, 1);
         check("done_in_ready_a",  in_ready_a,  0);
         check("done_in_ready_b",  in_ready_b,  0);
         check("done_busy_a",      busy_a,      1);
         check("sum_a",   out_sum_a,   exp_a);
         check("sum_b",   out_sum_b,   exp_b);
         check("count_a", out_count_a, n);
         check("count_b", out_count_b, n);
         check("ovf_a",   out_ovf_a,   ovf_a);
         check("ovf_b",   out_ovf_b,   ovf_b);
         // Junk beats offered while DONE must not be absorbed.
         in_valid    = 1'b1;
         in_data     = rand_prod();
         start       = poke && (h == 0);
         num_samples = CW'(n + 5);
         out_ready   = (h == hold);
         @(negedge ap_clk);
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      check("post_out_valid_a", out_valid_a, 0);
      check("post_busy_a",      busy_a,      0);
      check("post_busy_b",      busy_b,      0);
      @(negedge ap_clk);
      check("no_second_job_a",  busy_a,      0);
      $display("job n=%0d gap=%0d hold=%0d sum96=%0h sum89=%0h ovf89=%0b",
               n, gap_pct, hold, exp_a, exp_b, ovf_b);
   endtask

   initial begin
      ap_rst      = 1'b1;
      start       = 1'b0;
      num_samples = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;
      check_cleared("reset");

      // Reset in the middle of a job.
      start       = 1'b1;
      num_samples = CW'(10);
      @(negedge ap_clk);
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = PW'(i + 1);
         @(negedge ap_clk);
      end
      in_valid = 1'b0;
      ap_rst   = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check_cleared("midjob_reset");

      job_beats = '{PW'(1), PW'(1)};
      run_job(2, 0, 0, 1'b0);

      job_beats = '{PW'(5), PW'(7), PW'(1) << 88};
      run_job(3, 0, 0, 1'b0);

      job_beats = '{rand_prod(), rand_prod(), rand_prod(), rand_prod()};
      run_job(4, 50, 5, 1'b0);

      job_beats.delete();
      run_job(0, 0, 0, 1'b0);

      job_beats = '{'1, '1};
      run_job(2, 0, 1, 1'b0);

      job_beats = '{PW'(11), PW'(22), PW'(33)};
      run_job(3, 30, 2, 1'b1);

      for (int j = 0; j < 20; j++) begin
         int n;
         n = $urandom_range(8);
         job_beats.delete();
         for (int k = 0; k < n; k++) job_beats.push_back(rand_prod());
         run_job(n, $urandom_range(60), $urandom_range(3), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
